// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine:
// state encoding and a constant-width helper for the bit cursor.
package sar_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PROBE = ST_PROBE,
        S_DONE  = ST_DONE
    } state_e;

    // Smallest r with 2**r >= v; elaboration-time only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/comparator.sv
// Combinational magnitude comparator used as the search oracle:
// exactly one of g/e/l is high for any pair of operands.
module comparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         g,
    output logic         e,
    output logic         l
);

    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search: drives probes into a comparator oracle
// and resolves the hidden operand one bit per cycle, MSB first.
module sar_search
    import sar_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [W-1:0] probe,
    output logic         probe_valid,
    input  logic         g,
    input  logic         e,
    input  logic         l,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         found,
    output logic         err
);

    localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);

    state_e          state_q;
    logic [W-1:0]    probe_q;
    logic [W-1:0]    result_q;
    logic [CW-1:0]   cur_q;
    logic            verify_q;
    logic            found_q;
    logic            err_q;

    logic [W-1:0]    bit_m;
    logic [W-1:0]    below_m;
    logic            onehot;

    // Mask of the bit under decision and the trial bit one position lower.
    assign bit_m   = {{(W-1){1'b0}}, 1'b1} << cur_q;
    assign below_m = bit_m >> 1;
    assign onehot  = ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) ||
                     ({g, e, l} == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            result_q <= '0;
            cur_q    <= '0;
            verify_q <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        probe_q  <= bit_m << (W - 1 - int'(cur_q));
                        cur_q    <= CW'(W - 1);
                        verify_q <= 1'b0;
                        result_q <= '0;
                        found_q  <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (!onehot) begin
                        err_q    <= 1'b1;
                        found_q  <= 1'b0;
                        result_q <= probe_q;
                        state_q  <= S_DONE;
                    end else if (verify_q || e) begin
                        // A verify cycle without e means the oracle contradicted itself.
                        found_q  <= e;
                        result_q <= probe_q;
                        state_q  <= S_DONE;
                    end else if (cur_q != '0) begin
                        probe_q <= (g ? (probe_q & ~bit_m) : probe_q) | below_m;
                        cur_q   <= cur_q - CW'(1);
                    end else begin
                        probe_q  <= g ? (probe_q & ~bit_m) : probe_q;
                        verify_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign probe       = probe_q;
    assign probe_valid = (state_q == S_PROBE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign found       = found_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed table, randomized hidden
// values against a bit-trial reference model, illegal-oracle and reset cases.
module tb_sar_search;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  hidden;
    logic [W-1:0]  probe;
    logic          probe_valid;
    logic          g, e, l;
    logic          cg, ce, cl;
    logic          busy, done, found, err;
    logic [W-1:0]  result;
    logic          frc;
    logic [2:0]    fglc;
    logic [2*W+4:0] outs;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    always #5 clk = ~clk;

    comparator #(.W(W)) u_cmp (
        .a(probe), .b(hidden), .g(cg), .e(ce), .l(cl)
    );

    assign {g, e, l} = frc ? fglc : {cg, ce, cl};
    assign outs = {probe, probe_valid, busy, done, result, found, err};

    sar_search #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .probe(probe), .probe_valid(probe_valid),
        .g(g), .e(e), .l(l),
        .busy(busy), .done(done),
        .result(result), .found(found), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: try each bit from MSB down on top of the bits already
    // accepted; a trial below the hidden value is kept. Without a hit, the
    // accumulated value is probed once more as a verify step.
    task automatic model(input logic [W-1:0] h);
        logic [W-1:0] acc;
        logic [W-1:0] trial;
        exp_q.delete();
        acc = '0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = acc | (W'(1) << i);
            exp_q.push_back(trial);
            if (trial == h) return;
            if (trial < h) acc = trial;
        end
        exp_q.push_back(acc);
    endtask

    task automatic run_search(input logic [W-1:0] h, input int poke_at, input int force_at,
                              input int rst_at, output int k, output int ncyc, output bit saw_done);
        hidden = h;
        got_q.delete();
        k = 0; ncyc = 0; saw_done = 1'b0;
        @(negedge clk); start = 1'b1;
        for (int cyc = 0; cyc < 2 * W + 4; cyc++) begin
            @(negedge clk);
            start = 1'b0; frc = 1'b0; ncyc++;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (probe_valid) begin
                got_q.push_back(probe);
                k++;
                check("busy_in_probe", busy, 1);
                if (k == poke_at) start = 1'b1;
                if (k == force_at) begin frc = 1'b1; fglc = 3'b101; end
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1 check("async_reset_outs", outs, 0);
                    @(negedge clk);
                    check("no_done_in_reset", {done, busy}, 0);
                    rst_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic finish_checks(input string tag, input int k, input int ncyc, input bit saw_done,
                                 input logic [W-1:0] exp_res, input logic exp_found,
                                 input logic exp_err, input int exp_k);
        check({tag, "_done_seen"}, saw_done, 1);
        check({tag, "_k"}, k, exp_k);
        check({tag, "_done_latency"}, ncyc, k + 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_found"}, found, exp_found);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, busy}, 0);
        check({tag, "_result_held"}, {result, found, err}, {exp_res, exp_found, exp_err});
    endtask

    task automatic check_probes(input string tag);
        check({tag, "_nprobes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                check({tag, "_probe_seq"}, got_q[i], exp_q[i]);
                break;
            end
    endtask

    typedef struct {
        logic [W-1:0] hidden;
        int           poke_at;
        logic [W-1:0] exp_res;
        logic         exp_found;
        int           exp_k;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int  k, ncyc;
        bit  sd;
        logic [W-1:0] h;

        vecs[0] = '{8'd128, 0, 8'd128, 1'b1, 1};
        vecs[1] = '{8'd0,   0, 8'd0,   1'b1, 9};
        vecs[2] = '{8'd255, 0, 8'd255, 1'b1, 8};
        vecs[3] = '{8'd5,   3, 8'd5,   1'b1, 8};

        rst_n = 1'b0; start = 1'b0; frc = 1'b0; fglc = 3'b000; hidden = '0;
        #12 check("reset_outs", outs, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, probe_valid}, 0);

        foreach (vecs[i]) begin
            model(vecs[i].hidden);
            run_search(vecs[i].hidden, vecs[i].poke_at, 0, 0, k, ncyc, sd);
            finish_checks($sformatf("vec%0d", i), k, ncyc, sd, vecs[i].exp_res,
                          vecs[i].exp_found, 1'b0, vecs[i].exp_k);
            check_probes($sformatf("vec%0d", i));
        end

        // Directed sequence for hidden=5, independent of the model.
        check("h5_seq", {got_q[0], got_q[1], got_q[2], got_q[3]},
              {8'h80, 8'h40, 8'h20, 8'h10});
        check("h5_seq_tail", {got_q[4], got_q[5], got_q[6], got_q[7]},
              {8'h08, 8'h04, 8'h06, 8'h05});

        for (int n = 0; n < 24; n++) begin
            h = W'($urandom_range(0, (1 << W) - 1));
            model(h);
            run_search(h, 0, 0, 0, k, ncyc, sd);
            finish_checks($sformatf("rnd_h%0d", h), k, ncyc, sd, h, 1'b1, 1'b0, exp_q.size());
            check_probes($sformatf("rnd_h%0d", h));
        end

        // Illegal oracle response on the 3rd probe (0x20 when hidden=5).
        run_search(8'd5, 0, 3, 0, k, ncyc, sd);
        finish_checks("illegal_glc", k, ncyc, sd, 8'h20, 1'b0, 1'b1, 3);

        // Reset mid-search, then a clean search.
        run_search(8'd5, 0, 0, 4, k, ncyc, sd);
        check("rst_no_done", sd, 0);
        @(negedge clk);
        check("rst_outs_after_release", outs, 0);
        model(8'd77);
        run_search(8'd77, 0, 0, 0, k, ncyc, sd);
        finish_checks("post_rst_h77", k, ncyc, sd, 8'd77, 1'b1, 1'b0, exp_q.size());
        check_probes("post_rst_h77");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
